// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: default widths, ALU op / result-class
// codes and the bubble values loaded into the pipeline latches.
package ex_stage_pkg;

  localparam int EX_DW   = 32;
  localparam int EX_AW   = 5;
  localparam int EX_OPW  = 8;
  localparam int EX_SELW = 3;

  localparam logic [EX_OPW-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [EX_OPW-1:0] EXE_AND_OP = 8'h24;
  localparam logic [EX_OPW-1:0] EXE_OR_OP  = 8'h25;
  localparam logic [EX_OPW-1:0] EXE_XOR_OP = 8'h26;
  localparam logic [EX_OPW-1:0] EXE_NOR_OP = 8'h27;
  localparam logic [EX_OPW-1:0] EXE_SLL_OP = 8'h7C;
  localparam logic [EX_OPW-1:0] EXE_SRL_OP = 8'h02;
  localparam logic [EX_OPW-1:0] EXE_SRA_OP = 8'h03;

  localparam logic [EX_SELW-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [EX_SELW-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [EX_SELW-1:0] EXE_RES_SHIFT = 3'b010;

  // Bit positions inside the controller's {stall_mem, stall_ex, stall_id} vector.
  localparam int STALL_ID  = 0;
  localparam int STALL_EX  = 1;
  localparam int STALL_MEM = 2;

  typedef struct packed {
    logic [EX_OPW-1:0]  aluop;
    logic [EX_SELW-1:0] alusel;
    logic [EX_DW-1:0]   data1;
    logic [EX_DW-1:0]   data2;
    logic               we;
    logic [EX_AW-1:0]   waddr;
  } idex_t;

  typedef struct packed {
    logic               we;
    logic [EX_AW-1:0]   waddr;
    logic [EX_DW-1:0]   wdata;
  } exmem_t;

  localparam idex_t IDEX_BUBBLE = '{
    aluop:  EXE_NOP_OP,
    alusel: EXE_RES_NOP,
    data1:  '0,
    data2:  '0,
    we:     1'b0,
    waddr:  '0
  };

  localparam exmem_t EXMEM_BUBBLE = '{we: 1'b0, waddr: '0, wdata: '0};

endpackage

// File: rtl/ex_alu.sv
// Single-cycle logic/shift ALU. Purely combinational; the result class selects
// which unit drives the output, anything unrecognised yields zero.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DW   = EX_DW,
  parameter int OPW  = EX_OPW,
  parameter int SELW = EX_SELW
) (
  input  logic [OPW-1:0]  aluop_i,
  input  logic [SELW-1:0] alusel_i,
  input  logic [DW-1:0]   d1_i,
  input  logic [DW-1:0]   d2_i,
  output logic [DW-1:0]   result_o
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] shamt;
  logic [DW-1:0]  logic_res;
  logic [DW-1:0]  shift_res;

  // Shift amount comes from operand 1; its upper bits are ignored.
  assign shamt = d1_i[SHW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    result_o  = '0;

    unique case (aluop_i)
      EXE_AND_OP: logic_res = d1_i & d2_i;
      EXE_OR_OP:  logic_res = d1_i | d2_i;
      EXE_XOR_OP: logic_res = d1_i ^ d2_i;
      EXE_NOR_OP: logic_res = ~(d1_i | d2_i);
      default:    logic_res = '0;
    endcase

    unique case (aluop_i)
      EXE_SLL_OP: shift_res = d2_i << shamt;
      EXE_SRL_OP: shift_res = d2_i >> shamt;
      EXE_SRA_OP: shift_res = DW'($signed(d2_i) >>> shamt);
      default:    shift_res = '0;
    endcase

    unique case (alusel_i)
      EXE_RES_LOGIC: result_o = logic_res;
      EXE_RES_SHIFT: result_o = shift_res;
      default:       result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, logic/shift ALU, EX/MEM latch and a retirement
// counter, with stall/bubble/flush handling from the pipeline controller.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DW   = EX_DW,
  parameter int AW   = EX_AW,
  parameter int OPW  = EX_OPW,
  parameter int SELW = EX_SELW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  id_aluop_i,
  input  logic [SELW-1:0] id_alusel_i,
  input  logic [DW-1:0]   id_data1_i,
  input  logic [DW-1:0]   id_data2_i,
  input  logic            id_we_i,
  input  logic [AW-1:0]   id_waddr_i,
  input  logic [2:0]      stall_i,
  input  logic            flush_i,
  output logic            ex_we_o,
  output logic [AW-1:0]   ex_waddr_o,
  output logic [DW-1:0]   ex_wdata_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_waddr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [31:0]     retired_o
);

  idex_t       idex_q,    idex_d;
  exmem_t      exmem_q,   exmem_d;
  logic [31:0] retired_q, retired_d;
  logic [DW-1:0] alu_result;

  logic stall_id, stall_ex, stall_mem;
  assign stall_id  = stall_i[STALL_ID];
  assign stall_ex  = stall_i[STALL_EX];
  assign stall_mem = stall_i[STALL_MEM];

  ex_alu #(
    .DW   (DW),
    .OPW  (OPW),
    .SELW (SELW)
  ) u_alu (
    .aluop_i  (idex_q.aluop),
    .alusel_i (idex_q.alusel),
    .d1_i     (idex_q.data1),
    .d2_i     (idex_q.data2),
    .result_o (alu_result)
  );

  assign ex_we_o    = idex_q.we;
  assign ex_waddr_o = idex_q.waddr;
  assign ex_wdata_o = alu_result;

  assign mem_we_o    = exmem_q.we;
  assign mem_waddr_o = exmem_q.waddr;
  assign mem_wdata_o = exmem_q.wdata;
  assign retired_o   = retired_q;

  // A stage inserts a bubble when its upstream is stalled but it is free to move.
  always_comb begin
    idex_d = idex_q;
    if (flush_i) begin
      idex_d = IDEX_BUBBLE;
    end else if (stall_id && !stall_ex) begin
      idex_d = IDEX_BUBBLE;
    end else if (!stall_ex) begin
      idex_d = '{
        aluop:  id_aluop_i,
        alusel: id_alusel_i,
        data1:  id_data1_i,
        data2:  id_data2_i,
        we:     id_we_i,
        waddr:  id_waddr_i
      };
    end
  end

  always_comb begin
    exmem_d = exmem_q;
    if (flush_i) begin
      exmem_d = EXMEM_BUBBLE;
    end else if (stall_ex && !stall_mem) begin
      exmem_d = EXMEM_BUBBLE;
    end else if (!stall_mem) begin
      exmem_d = '{we: ex_we_o, waddr: ex_waddr_o, wdata: ex_wdata_o};
    end
  end

  // The entry in EX/MEM retires on any edge where MEM is not stalled; wraps naturally.
  always_comb begin
    retired_d = retired_q + {31'b0, (exmem_q.we && !stall_mem)};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q    <= IDEX_BUBBLE;
      exmem_q   <= EXMEM_BUBBLE;
      retired_q <= '0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      retired_q <= retired_d;
    end
  end

endmodule
